// File: rtl/protocol_table_updater.sv
// rtl/protocol_table_updater.sv - write-side engine for the 33-bit protocol index table
//
// Purpose:
//   Serialized read-modify-write of one 11-bit field of a table entry
//   {TCP, UDP, others}, plus a bulk init sweep writing one value to every entry.
//   The table is read through an asynchronous port addressed by tbl_addr.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req_valid/ready  update request handshake (ready only in IDLE)
//   req_addr         entry to update
//   req_proto        IP protocol byte selecting the field (6=TCP, 17=UDP, else others)
//   req_index        new field value
//   init_start       start bulk init (IDLE only, wins over req_valid)
//   init_value       value written to every entry during init
//   tbl_addr/we/din  table address and write port
//   tbl_rdata        table read data, combinational from tbl_addr
//   busy             high outside IDLE
//   done             one-cycle pulse after an update or init completes
//   err              one-cycle pulse when a request addresses beyond the table

module protocol_table_updater #(
    parameter int ADDR_W     = 11,
    parameter int FIELD_W    = 11,
    parameter int TABLE_SIZE = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [7:0]           req_proto,
    input  logic [FIELD_W-1:0]   req_index,
    input  logic                 init_start,
    input  logic [3*FIELD_W-1:0] init_value,
    output logic [ADDR_W-1:0]    tbl_addr,
    input  logic [3*FIELD_W-1:0] tbl_rdata,
    output logic                 tbl_we,
    output logic [3*FIELD_W-1:0] tbl_din,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int ENTRY_W = 3 * FIELD_W;
    // One extra bit so the bound test also works when TABLE_SIZE == 2**ADDR_W.
    localparam logic [ADDR_W:0]   SIZE_X = (ADDR_W + 1)'(TABLE_SIZE);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(TABLE_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_INIT
    } state_t;

    state_t               state_q;
    logic [ADDR_W-1:0]    tbl_addr_q;
    logic                 tbl_we_q;
    logic [ENTRY_W-1:0]   tbl_din_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic [ADDR_W-1:0]    cnt_q;
    logic [7:0]           proto_q;
    logic [FIELD_W-1:0]   index_q;
    logic [ENTRY_W-1:0]   merged_d;

    // Replace the selected field; the other two come from the current entry.
    always_comb begin
        merged_d = tbl_rdata;
        case (proto_q)
            8'd6:    merged_d[3*FIELD_W-1 -: FIELD_W] = index_q;
            8'd17:   merged_d[2*FIELD_W-1 -: FIELD_W] = index_q;
            default: merged_d[FIELD_W-1:0]            = index_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tbl_addr_q <= '0;
            tbl_we_q   <= 1'b0;
            tbl_din_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            proto_q    <= '0;
            index_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (init_start) begin
                        // First init write is presented in the cycle after entry.
                        state_q    <= S_INIT;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        tbl_addr_q <= '0;
                        tbl_we_q   <= 1'b1;
                        tbl_din_q  <= init_value;
                    end else if (req_valid) begin
                        if ({1'b0, req_addr} < SIZE_X) begin
                            state_q    <= S_RD;
                            busy_q     <= 1'b1;
                            tbl_addr_q <= req_addr;
                            proto_q    <= req_proto;
                            index_q    <= req_index;
                        end else begin
                            // Rejected: tbl_addr keeps its previous value.
                            err_q <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    tbl_din_q <= merged_d;
                    tbl_we_q  <= 1'b1;
                    state_q   <= S_WR;
                end
                S_WR: begin
                    tbl_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_IDLE;
                end
                S_INIT: begin
                    if (cnt_q == LAST) begin
                        tbl_we_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_IDLE;
                    end else begin
                        cnt_q      <= cnt_q + ADDR_W'(1);
                        tbl_addr_q <= cnt_q + ADDR_W'(1);
                        tbl_din_q  <= init_value;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign tbl_addr  = tbl_addr_q;
    assign tbl_we    = tbl_we_q;
    assign tbl_din   = tbl_din_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_protocol_table_updater.sv
// tb/tb_protocol_table_updater.sv - scoreboard bench for protocol_table_updater
module tb_protocol_table_updater;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [10:0] req_addr;
    logic [7:0]  req_proto;
    logic [10:0] req_index;
    logic        init_start;
    logic [32:0] init_value;
    logic [10:0] tbl_addr;
    logic [32:0] tbl_rdata;
    logic        tbl_we;
    logic [32:0] tbl_din;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          kind;   // 0 write, 1 done, 2 err
        logic [10:0] addr;
        logic [32:0] data;
    } ev_t;
    ev_t sbq[$];

    logic [32:0] mem [0:2047];

    always #5 clk = ~clk;

    protocol_table_updater #(
        .ADDR_W(11), .FIELD_W(11), .TABLE_SIZE(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_proto(req_proto), .req_index(req_index),
        .init_start(init_start), .init_value(init_value),
        .tbl_addr(tbl_addr), .tbl_rdata(tbl_rdata), .tbl_we(tbl_we), .tbl_din(tbl_din),
        .busy(busy), .done(done), .err(err)
    );

    // Table model: asynchronous read, synchronous write.
    assign tbl_rdata = mem[tbl_addr];
    always @(posedge clk) if (tbl_we === 1'b1) mem[tbl_addr] = tbl_din;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [10:0] a, input logic [32:0] d);
        ev_t e;
        e.kind = kind; e.addr = a; e.data = d;
        sbq.push_back(e);
    endtask

    task automatic pop_check(input int kind, input logic [10:0] a, input logic [32:0] d, input string nm);
        ev_t e;
        if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_%s: actual addr=%0h data=%0h required=no event", nm, a, d);
        end else begin
            e = sbq.pop_front();
            chk({nm, "_kind"}, 64'(kind), 64'(e.kind));
            if (kind == 0) begin
                chk("write_addr", 64'(a), 64'(e.addr));
                chk("write_data", 64'(d), 64'(e.data));
            end
        end
    endtask

    // Monitor: every observed output event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (tbl_we === 1'b1) pop_check(0, tbl_addr, tbl_din, "write");
        if (done === 1'b1)   pop_check(1, '0, '0, "done");
        if (err === 1'b1)    pop_check(2, '0, '0, "err");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"},   64'(tbl_we), 64'(0));
        chk({tag, "_addr"}, 64'(tbl_addr), 64'(0));
        chk({tag, "_din"},  64'(tbl_din), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_err"},  64'(err), 64'(0));
    endtask

    // Issue one update from an IDLE cycle; expects ready low for 2 cycles and done at T+3.
    task automatic do_update(input logic [10:0] a, input logic [7:0] p, input logic [10:0] ix,
                             input logic [32:0] exp_word);
        int n;
        push_ev(0, a, exp_word);
        push_ev(1, '0, '0);
        req_valid = 1'b1; req_addr = a; req_proto = p; req_index = ix;
        tick();
        req_valid = 1'b0;
        chk("rd_addr", 64'(tbl_addr), 64'(a));
        chk("rd_we", 64'(tbl_we), 64'(0));
        n = 0;
        while (!req_ready && n < 10) begin
            n++;
            tick();
        end
        chk("ready_low_cycles", 64'(n), 64'(2));
        chk("done_at_t3", 64'(done), 64'(1));
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n;
        n = 0;
        while (done !== 1'b1 && n < bound) begin
            n++;
            tick();
        end
        chk({tag, "_done_seen"}, 64'(done), 64'(1));
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_proto = '0; req_index = '0;
        init_start = 1'b0; init_value = '0;
        tick(); tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();
        chk("ready_after_reset", 64'(req_ready), 64'(1));

        // TCP field update on entry 5.
        mem[5] = {11'h7FF, 11'h000, 11'h155};
        do_update(11'd5, 8'd6, 11'h123, {11'h123, 11'h000, 11'h155});
        chk("mem5_tcp", 64'(mem[5]), 64'({11'h123, 11'h000, 11'h155}));

        // Back-to-back UDP then others on the original entry.
        mem[5] = {11'h7FF, 11'h000, 11'h155};
        do_update(11'd5, 8'd17, 11'h2AA, {11'h7FF, 11'h2AA, 11'h155});
        do_update(11'd5, 8'd1, 11'h001, {11'h7FF, 11'h2AA, 11'h001});
        chk("mem5_final", 64'(mem[5]), 64'({11'h7FF, 11'h2AA, 11'h001}));

        // Bulk init with zero over 16 entries.
        tick();
        for (int i = 0; i < 16; i++) push_ev(0, 11'(i), 33'h0);
        push_ev(1, '0, '0);
        init_value = 33'h0;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("init_busy", 64'(busy), 64'(1));
            chk("init_addr", 64'(tbl_addr), 64'(i));
            tick();
        end
        chk("init_done", 64'(done), 64'(1));
        chk("init_busy_end", 64'(busy), 64'(0));
        chk("mem5_zero", 64'(mem[5]), 64'(0));

        // Out-of-range request.
        tick();
        push_ev(2, '0, '0);
        req_valid = 1'b1; req_addr = 11'd20; req_proto = 8'd6; req_index = 11'h7FF;
        tick();
        req_valid = 1'b0;
        chk("err_pulse", 64'(err), 64'(1));
        chk("err_ready", 64'(req_ready), 64'(1));
        chk("err_no_we", 64'(tbl_we), 64'(0));
        tick();
        chk("err_one_cycle", 64'(err), 64'(0));

        // init_start beats a simultaneous request; request taken in the done cycle.
        for (int i = 0; i < 16; i++) push_ev(0, 11'(i), {11'h111, 11'h222, 11'h333});
        push_ev(1, '0, '0);
        push_ev(0, 11'd3, {11'h111, 11'h00F, 11'h333});
        push_ev(1, '0, '0);
        init_value = {11'h111, 11'h222, 11'h333};
        init_start = 1'b1;
        req_valid = 1'b1; req_addr = 11'd3; req_proto = 8'd17; req_index = 11'h00F;
        tick();
        init_start = 1'b0;
        chk("race_busy", 64'(busy), 64'(1));
        chk("race_not_ready", 64'(req_ready), 64'(0));
        wait_done("race_init", 40);
        chk("race_ready_in_done", 64'(req_ready), 64'(1));
        tick();
        req_valid = 1'b0;
        chk("race_rd_addr", 64'(tbl_addr), 64'(3));
        tick();
        wait_done("race_update", 10);
        chk("mem3_udp", 64'(mem[3]), 64'({11'h111, 11'h00F, 11'h333}));

        // Reset during WR.
        tick();
        mem[9] = '0;
        push_ev(0, 11'd9, {11'h7FF, 11'h000, 11'h000});
        req_valid = 1'b1; req_addr = 11'd9; req_proto = 8'd6; req_index = 11'h7FF;
        tick();
        req_valid = 1'b0;
        tick();
        chk("wr_we_before_rst", 64'(tbl_we), 64'(1));
        rst = 1'b1;
        tick();
        chk_reset_outputs("rst_wr");
        rst = 1'b0;
        tick();
        chk("rst_wr_ready", 64'(req_ready), 64'(1));
        do_update(11'd9, 8'd17, 11'h055, {11'h7FF, 11'h055, 11'h000});

        // Reset mid-INIT while the counter is at 7.
        tick();
        for (int i = 0; i < 8; i++) push_ev(0, 11'(i), {11'h0AB, 11'h0CD, 11'h0EF});
        init_value = {11'h0AB, 11'h0CD, 11'h0EF};
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("init_at_7", 64'(tbl_addr), 64'(7));
        rst = 1'b1;
        tick();
        chk_reset_outputs("rst_init");
        rst = 1'b0;
        tick();
        chk("mem7_written", 64'(mem[7]), 64'({11'h0AB, 11'h0CD, 11'h0EF}));
        chk("mem8_kept", 64'(mem[8]), 64'({11'h111, 11'h222, 11'h333}));
        do_update(11'd10, 8'd1, 11'h444, {11'h111, 11'h222, 11'h444});

        tick(); tick(); tick();
        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/protocol_table_updater.md
Name: protocol_table_updater

Overview:
- Write-side engine for the 33-bit protocol index table {TCP[32:22], UDP[21:11], others[10:0]} consumed by the group-4 index lookup.
- Accepts single-field update requests from the rule-update controller and performs a serialized read-modify-write so the other two fields survive.
- Also provides a bulk init sweep that writes one value to every entry.
- Drives the table's shared address/write port and reads back through its asynchronous distributed-RAM read port.

Parameters:
- ADDR_W, 11, table address width.
- FIELD_W, 11, width of one protocol index field; entry width is 3*FIELD_W.
- TABLE_SIZE, 2048, number of valid entries; addresses >= TABLE_SIZE are illegal.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  update request valid.
- req_ready  output  1  high only in IDLE; a request is accepted on req_valid && req_ready.
- req_addr  input  ADDR_W  table entry to update.
- req_proto  input  8  IP protocol byte selecting the field.
- req_index  input  FIELD_W  new field value.
- init_start  input  1  start bulk init (sampled in IDLE only).
- init_value  input  3*FIELD_W  value written to every entry during init.
- tbl_addr  output  ADDR_W  table address.
- tbl_rdata  input  3*FIELD_W  table read data, combinational from tbl_addr.
- tbl_we  output  1  table write enable.
- tbl_din  output  3*FIELD_W  table write data.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when an update or init completes.
- err  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset: state IDLE, tbl_we=0, tbl_addr=0, tbl_din=0, done=0, err=0, busy=0, init counter=0. The cycle after rst deasserts, req_ready=1.
- Reset mid-operation: the next edge forces IDLE with tbl_we=0. No partial write is issued afterwards. Entries already written stay written.
- States: IDLE, RD, WR, INIT.
- IDLE:
  - If init_start=1, go to INIT and clear the counter. init_start wins over a simultaneous req_valid, which is not accepted (req_ready is high but the acceptance is suppressed; the requester holds the request).
  - Otherwise, if req_valid=1, latch addr/proto/index.
  - If addr >= TABLE_SIZE, pulse err next cycle, perform no write, and stay in IDLE.
  - Otherwise go to RD.
- RD:
  - tbl_addr=latched addr, tbl_we=0.
  - At the clock edge, register the merged word and go to WR.
  - Merge rule: proto==6 replaces [32:22]; proto==17 replaces [21:11]; any other value replaces [10:0]. Remaining bits are taken from tbl_rdata.
- WR: tbl_addr=latched addr, tbl_we=1, tbl_din=merged word. At the clock edge go to IDLE and pulse done=1 for the following cycle.
- Timing:
  - Accept at edge T; RD during cycle T+1; write during T+2; done high during T+3, which is also the first cycle a new request can be accepted.
  - Throughput is one update per 3 cycles.
  - Requests are fully serialized, so back-to-back updates to the same address read the previous write (no hazard).
- INIT:
  - Each cycle: tbl_we=1, tbl_addr=counter, tbl_din=init_value (sampled each cycle; it must be held stable by the user).
  - The counter increments by 1 per cycle.
  - After writing TABLE_SIZE-1, go to IDLE and pulse done. Init takes exactly TABLE_SIZE write cycles. The counter does not wrap past TABLE_SIZE-1.
- init_start or req_valid outside IDLE is ignored. No queueing.
- tbl_addr holds its last value in IDLE. tbl_we is never high in IDLE or RD.

Test Plan:
- Entry 5 = {0x7FF,0x000,0x155}, request addr=5, proto=6, index=0x123 -> one tbl_we cycle at T+2 with addr=5, din={0x123,0x000,0x155}; done at T+3.
- Same entry, proto=17, index=0x2AA, then proto=1, index=0x001 back-to-back -> final entry {0x7FF,0x2AA,0x001}; req_ready low for exactly 2 cycles after each accept.
- init_start with init_value=0 and TABLE_SIZE=16 -> 16 consecutive tbl_we cycles with addr 0..15; done one cycle after addr 15; busy high throughout.
- TABLE_SIZE=16, request addr=20 -> err pulse, no tbl_we, req_ready stays 1.
- init_start and req_valid asserted in the same IDLE cycle -> INIT runs and the request is not accepted. The request is accepted in the cycle done is high after init.
- Assert rst during WR and separately mid-INIT at counter=7 -> no tbl_we after the reset edge; outputs at reset values; the next request completes normally.
